// File: rtl/multicycle_seq.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; strobes are combinational from state and inputs.
// Memory requests hold until ready; a wait that reaches TIMEOUT cycles halts the core, as does an illegal opcode.
module multicycle_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        link,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  // Last wait count before a still-low ready becomes a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic [31:0] retired_q, retired_d;

  logic is_ralu, is_ialu, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_illegal;

  always_comb begin
    is_ralu = 1'b0;
    is_jr   = 1'b0;
    if (op == 6'h00) begin
      case (func)
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: is_ralu = 1'b1;
        6'h08:                                                  is_jr   = 1'b1;
        default: ;
      endcase
    end
    is_ialu    = (op[5:3] == 3'b001);
    is_lw      = (op == 6'h23);
    is_sw      = (op == 6'h2B);
    is_beq     = (op == 6'h04);
    is_bne     = (op == 6'h05);
    is_j       = (op == 6'h02);
    is_jal     = (op == 6'h03);
    is_illegal = !(is_ralu || is_jr || is_ialu || is_lw || is_sw ||
                   is_beq || is_bne || is_j || is_jal);
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = 8'd0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 2'd0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (is_j || is_jal) begin
          pc_en   = 1'b1;
          pc_sel  = 2'd2;
          reg_we  = is_jal;
          link    = is_jal;
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_en   = 1'b1;
          pc_sel  = 2'd3;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          pc_en   = is_beq ? zero : !zero;
          pc_sel  = 2'd1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // Unused encodings recovering to FETCH do not count as a retirement.
    if (state_d == S_FETCH &&
        (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq with TIMEOUT = 4; obs packs state and all strobes.
module tb_multicycle_seq;

  logic        clk, rst_n;
  logic [5:0]  op, func;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we, mem_to_reg, link;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        illegal, timeout;
  logic [31:0] retired;
  logic [12:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_seq #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .link(link), .state(state),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  // {state, imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel, reg_we, mem_to_reg, link}
  assign obs = {state, imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel, reg_we, mem_to_reg, link};

  localparam logic [12:0] V_FETCH_GO   = {3'd0, 10'b1_0_0_1_1_00_0_0_0};
  localparam logic [12:0] V_FETCH_WAIT = {3'd0, 10'b1_0_0_0_0_00_0_0_0};
  localparam logic [12:0] V_DECODE     = {3'd1, 10'b0_0_0_0_0_00_0_0_0};
  localparam logic [12:0] V_DEC_JAL    = {3'd1, 10'b0_0_0_0_1_10_1_0_1};
  localparam logic [12:0] V_DEC_JR     = {3'd1, 10'b0_0_0_0_1_11_0_0_0};
  localparam logic [12:0] V_EXEC       = {3'd2, 10'b0_0_0_0_0_00_0_0_0};
  localparam logic [12:0] V_EXEC_BR_T  = {3'd2, 10'b0_0_0_0_1_01_0_0_0};
  localparam logic [12:0] V_EXEC_BR_N  = {3'd2, 10'b0_0_0_0_0_01_0_0_0};
  localparam logic [12:0] V_MEM_LW     = {3'd3, 10'b0_1_0_0_0_00_0_0_0};
  localparam logic [12:0] V_MEM_SW     = {3'd3, 10'b0_1_1_0_0_00_0_0_0};
  localparam logic [12:0] V_WB_ALU     = {3'd4, 10'b0_0_0_0_0_00_1_0_0};
  localparam logic [12:0] V_WB_LW      = {3'd4, 10'b0_0_0_0_0_00_1_1_0};
  localparam logic [12:0] V_HALT       = {3'd7, 10'b0_0_0_0_0_00_0_0_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time 3 units after a posedge with reset released.
  task automatic do_reset();
    rst_n = 1'b0; op = 6'h00; func = 6'h20; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; op = 6'h00; func = 6'h20; zero = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== V_FETCH_WAIT) begin errors++; $display("FAIL reset_obs got %h exp %h", obs, V_FETCH_WAIT); end
    checks++;
    if ({illegal, timeout, retired} !== 34'd0) begin
      errors++; $display("FAIL reset_flags got %b %b %h exp 0 0 0", illegal, timeout, retired);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    op = 6'h00; func = 6'h20; imem_ready = 1'b1; #1;
    checks++; if (obs !== V_FETCH_GO) begin errors++; $display("FAIL add_fetch got %h exp %h", obs, V_FETCH_GO); end
    tick(); imem_ready = 1'b0; #1;
    checks++; if (obs !== V_DECODE) begin errors++; $display("FAIL add_decode got %h exp %h", obs, V_DECODE); end
    tick();
    checks++; if (obs !== V_EXEC) begin errors++; $display("FAIL add_exec got %h exp %h", obs, V_EXEC); end
    tick();
    checks++; if (obs !== V_WB_ALU) begin errors++; $display("FAIL add_wb got %h exp %h", obs, V_WB_ALU); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL add_ret0 got %0d exp 0", retired); end
    tick();
    checks++; if (obs !== V_FETCH_WAIT) begin errors++; $display("FAIL add_back got %h exp %h", obs, V_FETCH_WAIT); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL add_ret1 got %0d exp 1", retired); end
  endtask

  task automatic test_lw_wait();
    do_reset();
    op = 6'h23; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== V_MEM_LW) begin errors++; $display("FAIL lw_mem_wait%0d got %h exp %h", i, obs, V_MEM_LW); end
      tick();
    end
    dmem_ready = 1'b1; #1;
    checks++; if (obs !== V_MEM_LW) begin errors++; $display("FAIL lw_mem_ready got %h exp %h", obs, V_MEM_LW); end
    tick(); dmem_ready = 1'b0; #1;
    checks++; if (obs !== V_WB_LW) begin errors++; $display("FAIL lw_wb got %h exp %h", obs, V_WB_LW); end
    tick();
    checks++; if (obs !== V_FETCH_WAIT) begin errors++; $display("FAIL lw_back got %h exp %h", obs, V_FETCH_WAIT); end
    checks++; if (retired !== 32'd1 || timeout !== 1'b0) begin
      errors++; $display("FAIL lw_ret got %0d/%b exp 1/0", retired, timeout);
    end
  endtask

  task automatic test_sw();
    do_reset();
    op = 6'h2B; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    dmem_ready = 1'b1; #1;
    checks++; if (obs !== V_MEM_SW) begin errors++; $display("FAIL sw_mem got %h exp %h", obs, V_MEM_SW); end
    tick(); dmem_ready = 1'b0; #1;
    checks++; if (obs !== V_FETCH_WAIT) begin errors++; $display("FAIL sw_back got %h exp %h", obs, V_FETCH_WAIT); end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic        zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [12:0] exp [4] = '{V_EXEC_BR_T, V_EXEC_BR_N, V_EXEC_BR_N, V_EXEC_BR_T};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = ops[k]; imem_ready = 1'b1; #1;
      tick(); imem_ready = 1'b0;
      tick();
      zero = zs[k]; #1;
      checks++;
      if (obs !== exp[k]) begin errors++; $display("FAIL branch%0d got %h exp %h", k, obs, exp[k]); end
      tick();
      checks++;
      if (state !== 3'd0 || retired !== 32'd1) begin
        errors++; $display("FAIL branch%0d_back got %0d/%0d exp 0/1", k, state, retired);
      end
    end
  endtask

  task automatic test_jumps();
    do_reset();
    op = 6'h03; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0; #1;
    checks++; if (obs !== V_DEC_JAL) begin errors++; $display("FAIL jal_decode got %h exp %h", obs, V_DEC_JAL); end
    tick();
    checks++; if (state !== 3'd0 || retired !== 32'd1) begin
      errors++; $display("FAIL jal_back got %0d/%0d exp 0/1", state, retired);
    end
    op = 6'h00; func = 6'h08; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0; #1;
    checks++; if (obs !== V_DEC_JR) begin errors++; $display("FAIL jr_decode got %h exp %h", obs, V_DEC_JR); end
    tick();
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL jr_ret got %0d exp 2", retired); end
  endtask

  task automatic test_illegal();
    do_reset();
    op = 6'h3F; imem_ready = 1'b1; #1;
    tick();
    checks++; if (obs !== V_DECODE) begin errors++; $display("FAIL ill_decode got %h exp %h", obs, V_DECODE); end
    tick(); dmem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs !== V_HALT || illegal !== 1'b1) begin
        errors++; $display("FAIL ill_halt%0d got %h/%b exp %h/1", i, obs, illegal, V_HALT);
      end
      tick();
    end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL ill_ret got %0d exp 0", retired); end
    #2 rst_n = 1'b0; #1;
    checks++; if (state !== 3'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL ill_reset got %0d/%b exp 0/0", state, illegal);
    end
    // Reserved R-type function code is also illegal.
    do_reset();
    op = 6'h00; func = 6'h05; imem_ready = 1'b1; #1;
    tick(); tick();
    checks++; if (state !== 3'd7 || illegal !== 1'b1) begin
      errors++; $display("FAIL ill_func got %0d/%b exp 7/1", state, illegal);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== V_FETCH_WAIT) begin errors++; $display("FAIL tmo_wait%0d got %h exp %h", i, obs, V_FETCH_WAIT); end
      tick();
    end
    checks++; if (state !== 3'd7 || timeout !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL tmo_halt got %0d/%b/%b exp 7/1/0", state, timeout, imem_req);
    end
    do_reset();
    imem_ready = 1'b0;
    tick(); tick(); tick();
    imem_ready = 1'b1; #1;
    checks++; if (obs !== V_FETCH_GO) begin errors++; $display("FAIL tmo_ready_wins got %h exp %h", obs, V_FETCH_GO); end
    tick();
    checks++; if (state !== 3'd1 || timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_normal got %0d/%b exp 1/0", state, timeout);
    end
  endtask

  task automatic test_async_abort();
    do_reset();
    op = 6'h2B; imem_ready = 1'b1; #1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    checks++; if (obs !== V_MEM_SW) begin errors++; $display("FAIL abort_pre got %h exp %h", obs, V_MEM_SW); end
    #2 rst_n = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL abort_drop got %b/%b/%0d exp 0/0/0", dmem_req, dmem_we, state);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    test_async_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
